// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the reg_file write-port arbiter.
// Sizes match the 8x8 reg_file (8-bit data, 3-bit address, 8 registers).
package rf_arb_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_DW    = 8;
    localparam int RF_AW    = 3;
    localparam int RF_DEPTH = 8;

    // Round-robin successor of a winner index, wrapping at n-1
    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
        return (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester bus and reg_file write-port signals of the write arbiter.
// The master side is the requesters plus reg_file; the slave side is the arbiter.
interface regfile_write_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = RF_DW,
    parameter int AW   = RF_AW
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rf_write;
    logic [AW-1:0]      rf_addr;
    logic [DW-1:0]      rf_data;
    logic [2:0]         grant_id;
    logic               init_done;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_write, rf_addr, rf_data, grant_id, init_done
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_write, rf_addr, rf_data, grant_id, init_done
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: one-hot grant on the first request
// at or after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [2:0]      i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [2:0]      o_idx,
    output logic            o_any
);
    always_comb begin
        int off;
        int best;
        off   = 0;
        best  = NREQ;
        o_idx = '0;
        o_any = 1'b0;
        o_gnt = '0;
        // Distance of each requester from the pointer; the smallest valid one wins
        for (int i = 0; i < NREQ; i++) begin
            off = (i >= int'(i_ptr)) ? i - int'(i_ptr) : i + NREQ - int'(i_ptr);
            if (i_req[i] && off < best) begin
                best  = off;
                o_idx = 3'(i);
                o_any = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            o_gnt[i] = o_any && (o_idx == 3'(i));
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Clears every reg_file register after reset, then grants the write port
// round-robin. Optional macro RF_ARB_ZERO_REG_EN hardwires register 0.
module regfile_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = RF_DW,
    parameter int AW   = RF_AW
) (
    input  logic               CLK,
    input  logic               RESET,
    regfile_write_arbiter_if.slave arb_bus
);
    // state    | meaning
    // ST_CLEAR | sweep writes zero to addresses 0..DEPTH-1, no grants
    // ST_RUN   | one round-robin grant per cycle, registered write

    rf_state_e     r_state;
    logic [AW-1:0] r_sweep_ptr;
    logic [2:0]    r_rr_ptr;
    logic          r_rf_write;
    logic [AW-1:0] r_rf_addr;
    logic [DW-1:0] r_rf_data;
    logic [2:0]    r_grant_id;
    logic          r_init_done;

    logic [NREQ-1:0] w_gnt;
    logic [2:0]      w_idx;
    logic            w_any;
    logic [AW-1:0]   w_win_addr;
    logic [DW-1:0]   w_win_data;
    logic            w_win_wr;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .i_req (arb_bus.req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_win_addr = arb_bus.req_addr[int'(w_idx)*AW +: AW];
    assign w_win_data = arb_bus.req_data[int'(w_idx)*DW +: DW];

`ifdef RF_ARB_ZERO_REG_EN
    assign w_win_wr = (w_win_addr != '0);
`else
    assign w_win_wr = 1'b1;
`endif

    // Gating with RESET keeps a request from being accepted on the reset edge
    assign arb_bus.req_ready = (r_state == ST_RUN && !RESET) ? w_gnt : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_CLEAR;
            r_sweep_ptr <= '0;
            r_rr_ptr    <= '0;
            r_rf_write  <= 1'b0;
            r_rf_addr   <= '0;
            r_rf_data   <= '0;
            r_grant_id  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_rf_write  <= 1'b1;
                    r_rf_addr   <= r_sweep_ptr;
                    r_rf_data   <= '0;
                    r_sweep_ptr <= r_sweep_ptr + 1'b1;
                    if (&r_sweep_ptr) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_any) begin
                        r_rf_write <= w_win_wr;
                        r_rf_addr  <= w_win_addr;
                        r_rf_data  <= w_win_data;
                        r_grant_id <= w_idx;
                        r_rr_ptr   <= rr_next(w_idx, NREQ);
                    end else begin
                        r_rf_write <= 1'b0;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign arb_bus.rf_write  = r_rf_write;
    assign arb_bus.rf_addr   = r_rf_addr;
    assign arb_bus.rf_data   = r_rf_data;
    assign arb_bus.grant_id  = r_grant_id;
    assign arb_bus.init_done = r_init_done;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear sweep, single grant,
// round-robin order, requests during CLEAR, reset in RUN, register-0 writes.
module tb_regfile_write_arbiter;
    import rf_arb_pkg::*;

    localparam int NREQ = 3;
    localparam int DW   = RF_DW;
    localparam int AW   = RF_AW;

    logic CLK;
    logic RESET;
    int   n_checks;
    int   n_fail;

    regfile_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) arb_bus ();

    regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .arb_bus (arb_bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        arb_bus.req_valid[i]          = v;
        arb_bus.req_addr[i*AW +: AW]  = a;
        arb_bus.req_data[i*DW +: DW]  = d;
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] g);
        chk({tag, "_wr"},   32'(arb_bus.rf_write), 32'd1);
        chk({tag, "_addr"}, 32'(arb_bus.rf_addr),  32'(a));
        chk({tag, "_data"}, 32'(arb_bus.rf_data),  32'(d));
        chk({tag, "_gid"},  32'(arb_bus.grant_id), 32'(g));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RESET    = 1'b1;
        arb_bus.req_valid = '0;
        arb_bus.req_addr  = '0;
        arb_bus.req_data  = '0;

        // 1: reset state and clear sweep with no requests
        step();
        step();
        chk("rst_ready", 32'(arb_bus.req_ready), 32'd0);
        chk("rst_wr",    32'(arb_bus.rf_write),  32'd0);
        chk("rst_addr",  32'(arb_bus.rf_addr),   32'd0);
        chk("rst_gid",   32'(arb_bus.grant_id),  32'd0);
        chk("rst_init",  32'(arb_bus.init_done), 32'd0);
        RESET = 1'b0;
        for (int k = 0; k < RF_DEPTH; k++) begin
            step();
            chk("sweep_wr",   32'(arb_bus.rf_write),  32'd1);
            chk("sweep_addr", 32'(arb_bus.rf_addr),   32'(k));
            chk("sweep_data", 32'(arb_bus.rf_data),   32'd0);
            chk("sweep_init", 32'(arb_bus.init_done), (k == RF_DEPTH - 1) ? 32'd1 : 32'd0);
        end
        step();
        chk("idle_wr",   32'(arb_bus.rf_write),  32'd0);
        chk("idle_init", 32'(arb_bus.init_done), 32'd1);
        chk("idle_addr", 32'(arb_bus.rf_addr),   32'd7);

        // 2: single request from req0
        set_req(0, 1'b1, 3'd5, 8'hA5);
        #1;
        chk("t2_ready", 32'(arb_bus.req_ready), 32'b001);
        step();
        chk_write("t2", 3'd5, 8'hA5, 3'd0);
        set_req(0, 1'b0, 3'd0, 8'h00);

        // Bring rr_ptr back to 0 via a single req2 grant (rr_ptr is 1 here)
        set_req(2, 1'b1, 3'd6, 8'h66);
        #1;
        chk("t2b_ready", 32'(arb_bus.req_ready), 32'b100);
        step();
        chk_write("t2b", 3'd6, 8'h66, 3'd2);
        set_req(2, 1'b0, 3'd0, 8'h00);
        step();
        chk("t2b_idle_wr", 32'(arb_bus.rf_write), 32'd0);

        // 3: all requesters continuously valid -> 0,1,2,0,1,2
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 3'(i + 1), 8'(8'h10 + i));
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_ready", 32'(arb_bus.req_ready), 32'(1 << (k % 3)));
            step();
            chk_write("t3", 3'((k % 3) + 1), 8'(8'h10 + (k % 3)), 3'(k % 3));
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 3'd0, 8'h00);
        step();

        // 5: reset while in RUN with req1 pending
        set_req(1, 1'b1, 3'd3, 8'h33);
        RESET = 1'b1;
        #1;
        chk("t5_ready", 32'(arb_bus.req_ready), 32'd0);
        step();
        chk("t5_wr",   32'(arb_bus.rf_write),  32'd0);
        chk("t5_init", 32'(arb_bus.init_done), 32'd0);
        RESET = 1'b0;

        // 4: req1 stays valid through the sweep; first grant right after it
        for (int k = 0; k < RF_DEPTH; k++) begin
            chk("t4_ready_clr", 32'(arb_bus.req_ready), 32'd0);
            step();
            chk("t4_sweep_addr", 32'(arb_bus.rf_addr), 32'(k));
        end
        chk("t4_init",  32'(arb_bus.init_done), 32'd1);
        chk("t4_ready", 32'(arb_bus.req_ready), 32'b010);
        step();
        chk_write("t4", 3'd3, 8'h33, 3'd1);
        set_req(1, 1'b0, 3'd0, 8'h00);

        // 6: write to register 0 from req2 (rr_ptr is 2 here)
        set_req(2, 1'b1, 3'd0, 8'hFF);
        #1;
        chk("t6_ready", 32'(arb_bus.req_ready), 32'b100);
        step();
        set_req(2, 1'b0, 3'd0, 8'h00);
`ifdef RF_ARB_ZERO_REG_EN
        chk("t6_wr", 32'(arb_bus.rf_write), 32'd0);
`else
        chk_write("t6", 3'd0, 8'hFF, 3'd2);
`endif
        // rr_ptr must have wrapped to 0: req0 beats req1
        set_req(0, 1'b1, 3'd4, 8'h44);
        set_req(1, 1'b1, 3'd2, 8'h22);
        #1;
        chk("t6_rr_ready", 32'(arb_bus.req_ready), 32'b001);
        step();
        chk_write("t6_rr0", 3'd4, 8'h44, 3'd0);
        set_req(0, 1'b0, 3'd0, 8'h00);
        #1;
        chk("t6_rr_ready1", 32'(arb_bus.req_ready), 32'b010);
        step();
        chk_write("t6_rr1", 3'd2, 8'h22, 3'd1);
        set_req(1, 1'b0, 3'd0, 8'h00);
        step();
        chk("t6_idle_wr",   32'(arb_bus.rf_write), 32'd0);
        chk("t6_hold_addr", 32'(arb_bus.rf_addr),  32'd2);
        chk("t6_hold_data", 32'(arb_bus.rf_data),  32'h22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
